// File: rtl/multicycle_ctl.sv
// Main sequencing FSM for the multi-cycle RV32 core: walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB and drives the datapath selects and enables.
module multicycle_ctl #(
  parameter int inst_width = 32,
  parameter int cnt_width  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run_in,
  input  logic [inst_width-1:0] inst_in,
  input  logic                  mem_ready_in,
  input  logic                  cond_in,
  output logic [2:0]            state_out,
  output logic                  mem_re_out,
  output logic                  mem_we_out,
  output logic                  mem_byte_out,
  output logic                  ir_we_out,
  output logic                  alu_latch_out,
  output logic                  alu_srcA_out,
  output logic                  alu_srcB_out,
  output logic                  reg_we_out,
  output logic [1:0]            wb_sel_out,
  output logic                  pc_we_out,
  output logic [1:0]            pc_sel_out,
  output logic                  retire_out,
  output logic                  trap_out,
  output logic [cnt_width-1:0]  instret_out
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_LUI    = 3'd4,
    CLS_JALR   = 3'd5,
    CLS_BRANCH = 3'd6,
    CLS_ILL    = 3'd7
  } cls_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [cnt_width-1:0] cnt_one = cnt_width'(1);

  state_t state, next_state;
  cls_t   cls;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_inst_bits;

  logic [cnt_width-1:0] instret;

  assign opcode = inst_in[6:0];
  assign funct3 = inst_in[14:12];
  assign funct7 = inst_in[31:25];
  // rd/rs fields and immediates are datapath concerns, not sequencing ones
  assign unused_inst_bits = ^{inst_in[24:15], inst_in[11:7]};

  always_comb begin
    cls = CLS_ILL;
    unique case (opcode)
      OP_R: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111: cls = CLS_R;
            default:                                        cls = CLS_ILL;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000 || funct3 == 3'b101) cls = CLS_R;
        end
      end
      OP_I: begin
        case (funct3)
          3'b000, 3'b100, 3'b110, 3'b111: cls = CLS_I;
          3'b001: if (funct7 == F7_BASE) cls = CLS_I;
          3'b101: if (funct7 == F7_BASE || funct7 == F7_ALT) cls = CLS_I;
          default: cls = CLS_ILL;
        endcase
      end
      OP_LOAD:   if (funct3 == 3'b010 || funct3 == 3'b000) cls = CLS_LOAD;
      OP_STORE:  if (funct3 == 3'b010 || funct3 == 3'b000) cls = CLS_STORE;
      OP_LUI:    cls = CLS_LUI;
      OP_JALR:   if (funct3 == 3'b000) cls = CLS_JALR;
      OP_BRANCH: if (funct3 == 3'b000 || funct3 == 3'b001) cls = CLS_BRANCH;
      default:   cls = CLS_ILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      instret <= '0;
    end else begin
      state <= next_state;
      if (retire_out) instret <= instret + cnt_one;
    end
  end

  always_comb begin
    next_state    = state;
    mem_re_out    = 1'b0;
    mem_we_out    = 1'b0;
    mem_byte_out  = 1'b0;
    ir_we_out     = 1'b0;
    alu_latch_out = 1'b0;
    alu_srcA_out  = 1'b0;
    alu_srcB_out  = 1'b0;
    reg_we_out    = 1'b0;
    wb_sel_out    = 2'd0;
    pc_we_out     = 1'b0;
    pc_sel_out    = 2'd0;
    retire_out    = 1'b0;
    trap_out      = 1'b0;

    unique case (state)
      IDLE: begin
        if (run_in) next_state = FETCH;
      end

      FETCH: begin
        mem_re_out = 1'b1;
        if (mem_ready_in) begin
          ir_we_out  = 1'b1;
          next_state = DECODE;
        end
      end

      DECODE: begin
        next_state = (cls == CLS_ILL) ? TRAP : EXEC;
      end

      EXEC: begin
        alu_latch_out = 1'b1;
        alu_srcA_out  = (cls == CLS_LUI);
        alu_srcB_out  = (cls != CLS_R) && (cls != CLS_BRANCH);
        if (cls == CLS_BRANCH) begin
          pc_we_out  = 1'b1;
          pc_sel_out = cond_in ? 2'd1 : 2'd0;
          retire_out = 1'b1;
          next_state = run_in ? FETCH : IDLE;
        end else if (cls == CLS_LOAD || cls == CLS_STORE) begin
          next_state = MEM;
        end else begin
          next_state = WB;
        end
      end

      MEM: begin
        mem_re_out   = (cls == CLS_LOAD);
        mem_we_out   = (cls == CLS_STORE);
        mem_byte_out = (funct3 == 3'b000);
        if (mem_ready_in) begin
          if (cls == CLS_STORE) begin
            pc_we_out  = 1'b1;
            retire_out = 1'b1;
            next_state = run_in ? FETCH : IDLE;
          end else begin
            next_state = WB;
          end
        end
      end

      WB: begin
        reg_we_out = 1'b1;
        pc_we_out  = 1'b1;
        retire_out = 1'b1;
        if (cls == CLS_LOAD)      wb_sel_out = 2'd1;
        else if (cls == CLS_JALR) wb_sel_out = 2'd2;
        pc_sel_out = (cls == CLS_JALR) ? 2'd2 : 2'd0;
        next_state = run_in ? FETCH : IDLE;
      end

      TRAP: begin
        trap_out = 1'b1;
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign state_out   = state;
  assign instret_out = instret;

endmodule

// File: tb/tb_multicycle_ctl.sv
// Directed bench for multicycle_ctl: a per-cycle vector table for the main
// instruction mix, then hand-written sequences for reset and decode corners.
module tb_multicycle_ctl;

  logic        clk;
  logic        rst_n;
  logic        run_in;
  logic [31:0] inst_in;
  logic        mem_ready_in;
  logic        cond_in;

  logic [2:0]  state_out;
  logic        mem_re_out, mem_we_out, mem_byte_out, ir_we_out;
  logic        alu_latch_out, alu_srcA_out, alu_srcB_out, reg_we_out;
  logic [1:0]  wb_sel_out;
  logic        pc_we_out;
  logic [1:0]  pc_sel_out;
  logic        retire_out, trap_out;
  logic [31:0] instret_out;

  logic [2:0]  s_state_out;
  logic        s_mem_re, s_mem_we, s_mem_byte, s_ir_we, s_alu_latch;
  logic        s_src_a, s_src_b, s_reg_we, s_pc_we, s_retire, s_trap;
  logic [1:0]  s_wb_sel, s_pc_sel;
  logic [2:0]  s_instret;

  logic [14:0] ctl_act;

  int checks;
  int errors;

  multicycle_ctl #(.inst_width(32), .cnt_width(32)) dut (
    .clk(clk), .rst_n(rst_n), .run_in(run_in), .inst_in(inst_in),
    .mem_ready_in(mem_ready_in), .cond_in(cond_in),
    .state_out(state_out), .mem_re_out(mem_re_out), .mem_we_out(mem_we_out),
    .mem_byte_out(mem_byte_out), .ir_we_out(ir_we_out),
    .alu_latch_out(alu_latch_out), .alu_srcA_out(alu_srcA_out),
    .alu_srcB_out(alu_srcB_out), .reg_we_out(reg_we_out),
    .wb_sel_out(wb_sel_out), .pc_we_out(pc_we_out), .pc_sel_out(pc_sel_out),
    .retire_out(retire_out), .trap_out(trap_out), .instret_out(instret_out)
  );

  // Narrow counter copy so the wrap to zero is reached within a short run
  multicycle_ctl #(.inst_width(32), .cnt_width(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .run_in(run_in), .inst_in(inst_in),
    .mem_ready_in(mem_ready_in), .cond_in(cond_in),
    .state_out(s_state_out), .mem_re_out(s_mem_re), .mem_we_out(s_mem_we),
    .mem_byte_out(s_mem_byte), .ir_we_out(s_ir_we),
    .alu_latch_out(s_alu_latch), .alu_srcA_out(s_src_a),
    .alu_srcB_out(s_src_b), .reg_we_out(s_reg_we),
    .wb_sel_out(s_wb_sel), .pc_we_out(s_pc_we), .pc_sel_out(s_pc_sel),
    .retire_out(s_retire), .trap_out(s_trap), .instret_out(s_instret)
  );

  // Field order: re we byte ir_we latch srcA srcB reg_we wb_sel pc_we pc_sel retire trap
  assign ctl_act = {mem_re_out, mem_we_out, mem_byte_out, ir_we_out, alu_latch_out,
                    alu_srcA_out, alu_srcB_out, reg_we_out, wb_sel_out, pc_we_out,
                    pc_sel_out, retire_out, trap_out};

  localparam logic [14:0] C_IDLE    = 15'b0_0_0_0_0_0_0_0_00_0_00_0_0;
  localparam logic [14:0] C_FWAIT   = 15'b1_0_0_0_0_0_0_0_00_0_00_0_0;
  localparam logic [14:0] C_FETCH   = 15'b1_0_0_1_0_0_0_0_00_0_00_0_0;
  localparam logic [14:0] C_EX_R    = 15'b0_0_0_0_1_0_0_0_00_0_00_0_0;
  localparam logic [14:0] C_EX_IMM  = 15'b0_0_0_0_1_0_1_0_00_0_00_0_0;
  localparam logic [14:0] C_EX_LUI  = 15'b0_0_0_0_1_1_1_0_00_0_00_0_0;
  localparam logic [14:0] C_EX_BT   = 15'b0_0_0_0_1_0_0_0_00_1_01_1_0;
  localparam logic [14:0] C_EX_BN   = 15'b0_0_0_0_1_0_0_0_00_1_00_1_0;
  localparam logic [14:0] C_MEM_LW  = 15'b1_0_0_0_0_0_0_0_00_0_00_0_0;
  localparam logic [14:0] C_MEM_SB  = 15'b0_1_1_0_0_0_0_0_00_1_00_1_0;
  localparam logic [14:0] C_WB_ALU  = 15'b0_0_0_0_0_0_0_1_00_1_00_1_0;
  localparam logic [14:0] C_WB_LD   = 15'b0_0_0_0_0_0_0_1_01_1_00_1_0;
  localparam logic [14:0] C_WB_JALR = 15'b0_0_0_0_0_0_0_1_10_1_10_1_0;
  localparam logic [14:0] C_TRAP    = 15'b0_0_0_0_0_0_0_0_00_0_00_0_1;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_JALR = 32'h000080E7;
  localparam logic [31:0] I_SB   = 32'h00208023;
  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LUI  = 32'h123450B7;
  localparam logic [31:0] I_ILL  = 32'h0000007F;
  localparam logic [31:0] I_SRAI = 32'h4030D093;
  localparam logic [31:0] I_SLT  = 32'h0020A1B3;

  typedef struct {
    logic        run;
    logic [31:0] inst;
    logic        ready;
    logic        cond;
    logic [2:0]  exp_state;
    logic [14:0] exp_ctl;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add_vec(input logic run, input logic [31:0] inst, input logic ready,
                         input logic cond, input logic [2:0] st, input logic [14:0] ctl,
                         input logic [31:0] cnt);
    vec_t v;
    v.run = run; v.inst = inst; v.ready = ready; v.cond = cond;
    v.exp_state = st; v.exp_ctl = ctl; v.exp_cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic run, input logic [31:0] inst,
                               input logic ready, input logic cond);
    run_in       = run;
    inst_in      = inst;
    mem_ready_in = ready;
    cond_in      = cond;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] st,
                           input logic [14:0] ctl, input logic [31:0] cnt);
    checkOutput({tag, " state"}, 32'(state_out), 32'(st));
    checkOutput({tag, " ctl"}, 32'(ctl_act), 32'(ctl));
    checkOutput({tag, " instret"}, instret_out, cnt);
    checkOutput({tag, " instret3"}, 32'(s_instret), 32'(cnt[2:0]));
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // ADD: F D E WB
    add_vec(1, I_ADD, 1, 0, 3'd0, C_IDLE,   0);
    add_vec(1, I_ADD, 1, 0, 3'd1, C_FETCH,  0);
    add_vec(1, I_ADD, 1, 0, 3'd2, C_IDLE,   0);
    add_vec(1, I_ADD, 1, 0, 3'd3, C_EX_R,   0);
    add_vec(1, I_ADD, 1, 0, 3'd5, C_WB_ALU, 0);
    // LW with two memory wait cycles
    add_vec(1, I_LW, 1, 0, 3'd1, C_FETCH,  1);
    add_vec(1, I_LW, 1, 0, 3'd2, C_IDLE,   1);
    add_vec(1, I_LW, 1, 0, 3'd3, C_EX_IMM, 1);
    add_vec(1, I_LW, 0, 0, 3'd4, C_MEM_LW, 1);
    add_vec(1, I_LW, 0, 0, 3'd4, C_MEM_LW, 1);
    add_vec(1, I_LW, 1, 0, 3'd4, C_MEM_LW, 1);
    add_vec(1, I_LW, 1, 0, 3'd5, C_WB_LD,  1);
    // BEQ taken, then not taken
    add_vec(1, I_BEQ, 1, 1, 3'd1, C_FETCH, 2);
    add_vec(1, I_BEQ, 1, 1, 3'd2, C_IDLE,  2);
    add_vec(1, I_BEQ, 1, 1, 3'd3, C_EX_BT, 2);
    add_vec(1, I_BEQ, 1, 0, 3'd1, C_FETCH, 3);
    add_vec(1, I_BEQ, 1, 0, 3'd2, C_IDLE,  3);
    add_vec(1, I_BEQ, 1, 0, 3'd3, C_EX_BN, 3);
    // JALR
    add_vec(1, I_JALR, 1, 0, 3'd1, C_FETCH,   4);
    add_vec(1, I_JALR, 1, 0, 3'd2, C_IDLE,    4);
    add_vec(1, I_JALR, 1, 0, 3'd3, C_EX_IMM,  4);
    add_vec(1, I_JALR, 1, 0, 3'd5, C_WB_JALR, 4);
    // SB retires from MEM
    add_vec(1, I_SB, 1, 0, 3'd1, C_FETCH,  5);
    add_vec(1, I_SB, 1, 0, 3'd2, C_IDLE,   5);
    add_vec(1, I_SB, 1, 0, 3'd3, C_EX_IMM, 5);
    add_vec(1, I_SB, 1, 0, 3'd4, C_MEM_SB, 5);
    // ADDI with a fetch wait, run dropped in EXEC
    add_vec(1, I_ADDI, 0, 0, 3'd1, C_FWAIT,  6);
    add_vec(1, I_ADDI, 1, 0, 3'd1, C_FETCH,  6);
    add_vec(1, I_ADDI, 1, 0, 3'd2, C_IDLE,   6);
    add_vec(0, I_ADDI, 1, 0, 3'd3, C_EX_IMM, 6);
    add_vec(0, I_ADDI, 1, 0, 3'd5, C_WB_ALU, 6);
    add_vec(0, I_ADDI, 1, 0, 3'd0, C_IDLE,   7);
    add_vec(0, I_ADDI, 1, 0, 3'd0, C_IDLE,   7);
    // LUI: the narrow counter wraps 7 -> 0 on this retire
    add_vec(1, I_LUI, 1, 0, 3'd0, C_IDLE,   7);
    add_vec(1, I_LUI, 1, 0, 3'd1, C_FETCH,  7);
    add_vec(1, I_LUI, 1, 0, 3'd2, C_IDLE,   7);
    add_vec(1, I_LUI, 1, 0, 3'd3, C_EX_LUI, 7);
    add_vec(1, I_LUI, 1, 0, 3'd5, C_WB_ALU, 7);
    // Illegal opcode sticks in TRAP
    add_vec(1, I_ILL, 1, 0, 3'd1, C_FETCH, 8);
    add_vec(1, I_ILL, 1, 0, 3'd2, C_IDLE,  8);
    for (int k = 0; k < 10; k++) add_vec(1, I_ILL, 1, 0, 3'd6, C_TRAP, 8);

    rst_n = 1'b0;
    applyStimulus(0, 32'h0, 0, 0);
    #12;
    check_all("reset", 3'd0, C_IDLE, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].run, vecs[i].inst, vecs[i].ready, vecs[i].cond);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_ctl, vecs[i].exp_cnt);
      @(negedge clk);
    end

    // Asynchronous reset out of TRAP, between clock edges
    #3 rst_n = 1'b0;
    #1 check_all("async_rst", 3'd0, C_IDLE, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // SRAI with funct7=0100000 is legal and reaches EXEC
    applyStimulus(1, I_SRAI, 1, 0);
    repeat (3) @(negedge clk);
    #1 checkOutput("srai_exec", 32'(state_out), 32'd3);
    applyStimulus(0, I_SRAI, 1, 0);
    repeat (2) @(negedge clk);
    #1 checkOutput("srai_idle", 32'(state_out), 32'd0);
    checkOutput("srai_instret", instret_out, 32'd1);

    // SLT is outside the supported R set and traps
    applyStimulus(1, I_SLT, 1, 0);
    repeat (3) @(negedge clk);
    #1 checkOutput("slt_trap_state", 32'(state_out), 32'd6);
    checkOutput("slt_trap_out", 32'(trap_out), 32'd1);
    checkOutput("slt_instret", instret_out, 32'd1);

    // Reset asserted in WB aborts without any enable or retire
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, I_ADD, 1, 0);
    repeat (4) @(negedge clk);
    #1 check_all("add_wb", 3'd5, C_WB_ALU, 0);
    #2 rst_n = 1'b0;
    #1 check_all("rst_in_wb", 3'd0, C_IDLE, 0);
    @(negedge clk);
    #1 check_all("rst_held", 3'd0, C_IDLE, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
